// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sm_pkg
// Brief    : Shared constants and types for the SM instruction fetch slice.
// Revision : 1.0 - initial release
// ============================================================================
package sm_pkg;

    localparam int DEPTH_WARP          = 2;
    localparam int CODE_MEM_ADDR_WIDTH = 16;
    localparam int CODE_MEM_DATA_WIDTH = 64;
    localparam int INST_BYTES          = 8;

    typedef logic [1:0] fetch_state_e;
    localparam fetch_state_e c_IDLE = 2'd0;
    localparam fetch_state_e c_REQ  = 2'd1;
    localparam fetch_state_e c_WAIT = 2'd2;

    typedef struct packed {
        logic                           active;
        logic                           pending;
        logic [CODE_MEM_ADDR_WIDTH-1:0] pc;
    } warp_ctx_t;

endpackage
`default_nettype wire

// File: rtl/sm_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sm_rr_arbiter
// Brief    : Combinational round-robin pick: first request at or after i_ptr.
// Revision : 1.0 - initial release
// ============================================================================
module sm_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_any_grant
);

    // Scan from the far end so the closest request to the pointer is assigned last.
    always_comb begin
        o_grant_idx = '0;
        o_any_grant = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[i_ptr + IDX_W'(k)]) begin
                o_grant_idx = i_ptr + IDX_W'(k);
                o_any_grant = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sm_fetch.sv
`default_nettype none
// ============================================================================
// Module   : sm_fetch
// Brief    : Per-SM instruction fetch; round-robin warp pick, one outstanding
//            code-memory read, 1-cycle valid pulse towards sm_decode.
//            Optional perf counters when FETCH_PERF_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module sm_fetch
    import sm_pkg::*;
#(
    parameter int WID_W     = DEPTH_WARP,
    parameter int NUM_WARPS = 1 << WID_W,
    parameter int ADDR_W    = CODE_MEM_ADDR_WIDTH,
    parameter int DATA_W    = CODE_MEM_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              warp_start_i,
    input  logic [WID_W-1:0]  warp_start_wid_i,
    input  logic [ADDR_W-1:0] warp_start_pc_i,
    input  logic              warp_release_i,
    input  logic [WID_W-1:0]  warp_release_wid_i,
    input  logic              pc_redirect_i,
    input  logic [ADDR_W-1:0] pc_redirect_pc_i,
    input  logic              warp_done_i,
    input  logic              fetch_stall_i,
    output logic              mem_req_valid_o,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    input  logic              mem_req_ready_i,
    input  logic              mem_rsp_valid_i,
    input  logic [DATA_W-1:0] mem_rsp_data_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [WID_W-1:0]  wid_o,
    output logic              busy_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt_o,
    output logic [31:0]       perf_stall_cnt_o
`endif
);

    fetch_state_e      r_state;
    logic [WID_W-1:0]  r_sel_wid;
    logic [WID_W-1:0]  r_rr_ptr;
    logic [ADDR_W-1:0] r_req_addr;
    logic              r_pc_dirty;
    logic [NUM_WARPS-1:0] r_active;
    logic [NUM_WARPS-1:0] r_pending;
    logic [ADDR_W-1:0] r_pc [NUM_WARPS];
    logic              r_valid;
    logic [DATA_W-1:0] r_inst;
    logic [WID_W-1:0]  r_wid;

    logic [NUM_WARPS-1:0] w_eligible;
    logic [NUM_WARPS-1:0] w_start_hit;
    logic [NUM_WARPS-1:0] w_rel_hit;
    logic [NUM_WARPS-1:0] w_inflight;
    logic [WID_W-1:0]     w_grant_idx;
    logic                 w_any_grant;
    logic                 w_launch;
    logic                 w_accept;
    logic                 w_rsp_take;
    logic                 w_sel_pc_touched;

    assign w_eligible = r_active & ~r_pending;

    always_comb begin
        w_start_hit = '0;
        w_rel_hit   = '0;
        w_inflight  = '0;
        for (int w = 0; w < NUM_WARPS; w++) begin
            w_start_hit[w] = warp_start_i   && (warp_start_wid_i   == WID_W'(w));
            w_rel_hit[w]   = warp_release_i && (warp_release_wid_i == WID_W'(w));
            w_inflight[w]  = (r_state != c_IDLE) && (r_sel_wid == WID_W'(w));
        end
    end

    sm_rr_arbiter #(
        .N     (NUM_WARPS),
        .IDX_W (WID_W)
    ) u_arb (
        .i_req       (w_eligible),
        .i_ptr       (r_rr_ptr),
        .o_grant_idx (w_grant_idx),
        .o_any_grant (w_any_grant)
    );

    assign w_launch   = (r_state == c_IDLE) && !fetch_stall_i && w_any_grant;
    assign w_accept   = (r_state == c_REQ) && mem_req_ready_i;
    assign w_rsp_take = (r_state == c_WAIT) && mem_rsp_valid_i;

    // A start or redirect landing while the request waits must survive the accept increment.
    assign w_sel_pc_touched = w_start_hit[r_sel_wid] || (w_rel_hit[r_sel_wid] && pc_redirect_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_sel_wid  <= '0;
            r_rr_ptr   <= '0;
            r_req_addr <= '0;
            r_pc_dirty <= 1'b0;
            r_valid    <= 1'b0;
            r_inst     <= '0;
            r_wid      <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_launch) begin
                        r_sel_wid  <= w_grant_idx;
                        r_req_addr <= r_pc[w_grant_idx];
                        r_pc_dirty <= 1'b0;
                        r_state    <= c_REQ;
                    end
                end
                c_REQ: begin
                    if (w_sel_pc_touched) begin
                        r_pc_dirty <= 1'b1;
                    end
                    if (w_accept) begin
                        r_rr_ptr <= r_sel_wid + WID_W'(1);
                        r_state  <= c_WAIT;
                    end
                end
                c_WAIT: begin
                    if (w_rsp_take) begin
                        r_valid <= 1'b1;
                        r_inst  <= mem_rsp_data_i;
                        r_wid   <= r_sel_wid;
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Per-warp context; start has priority over everything else for its warp.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= '0;
            r_pending <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                r_pc[w] <= '0;
            end
        end else begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (w_start_hit[w]) begin
                    r_active[w]  <= 1'b1;
                    r_pending[w] <= 1'b0;
                    r_pc[w]      <= warp_start_pc_i;
                end else begin
                    if (w_accept && w_inflight[w]) begin
                        r_pending[w] <= 1'b1;
                    end else if (w_rel_hit[w] && !w_inflight[w]) begin
                        r_pending[w] <= 1'b0;
                    end
                    if (w_rel_hit[w] && pc_redirect_i) begin
                        r_pc[w] <= pc_redirect_pc_i;
                    end else if (w_accept && w_inflight[w] && !r_pc_dirty) begin
                        r_pc[w] <= r_req_addr + ADDR_W'(INST_BYTES);
                    end
                    if (w_rel_hit[w] && warp_done_i) begin
                        r_active[w] <= 1'b0;
                    end
                end
            end
        end
    end

    assign mem_req_valid_o = (r_state == c_REQ);
    assign mem_req_addr_o  = r_req_addr;
    assign valid_o         = r_valid;
    assign inst_o          = r_inst;
    assign wid_o           = r_wid;
    assign busy_o          = (|r_active) || (r_state != c_IDLE);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_stall_evt;

    assign w_stall_evt = ((r_state == c_IDLE) && w_any_grant && fetch_stall_i) ||
                         ((r_state == c_REQ) && !mem_req_ready_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (r_valid && (r_perf_fetch != '1)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_stall_evt && (r_perf_stall != '1)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt_o = r_perf_fetch;
    assign perf_stall_cnt_o = r_perf_stall;
`endif

endmodule
`default_nettype wire
